rpn_stack_eval: RTL and testbench

Downstream consumer of the digit-to-number parser in the UART RPN calculator. It accepts completed operand words (the parser's ready pulse plus 16-bit value) and operator tokens, and keeps them on a fixed-depth operand stack. It executes binary operators through a multi-cycle fetch/execute/write sequence. It exposes the top of stack, depth and sticky error flags to the UART result formatter.

---
 rtl/rpn_pkg.sv | 23 ++
 rtl/rpn_alu.sv | 25 ++
 rtl/rpn_stack_eval.sv | 165 ++++++++++++++++
 tb/tb_rpn_stack_eval.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator: operator tokens, evaluator
// FSM states and default datapath sizing.
package rpn_pkg;

    localparam int RPN_WIDTH = 16;
    localparam int RPN_DEPTH = 8;
    localparam int RPN_PTR_W = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_WRITE = 2'b11
    } state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational binary-operator unit for the RPN evaluator.
// Unsigned arithmetic, modulo 2^WIDTH; CLR never reaches this unit.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = RPN_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r
);

    // Select the operator result; products keep only the low WIDTH bits.
    always_comb begin
        r = '0;
        case (op_e'(op))
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/rpn_stack_eval.sv
// RPN operand stack and operator sequencer. Operands are pushed in one
// cycle; binary operators run IDLE -> FETCH -> EXEC -> WRITE.
module rpn_stack_eval
    import rpn_pkg::*;
#(
    parameter int WIDTH = RPN_WIDTH,
    parameter int DEPTH = RPN_DEPTH,
    parameter int PTR_W = RPN_PTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               num_valid,
    input  logic [WIDTH-1:0]   num_in,
    input  logic               op_valid,
    input  logic [1:0]         op,
    output logic [WIDTH-1:0]   top,
    output logic [PTR_W:0]     depth,
    output logic               busy,
    output logic               result_valid,
    output logic               err_overflow,
    output logic               err_underflow,
    output logic               err_drop
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_C   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   TWO_C   = (PTR_W+1)'(2);
    localparam logic [PTR_W-1:0] IDX1_C  = PTR_W'(1);
    localparam logic [PTR_W-1:0] IDX2_C  = PTR_W'(2);

    logic [WIDTH-1:0] mem [DEPTH];

    state_e           state_q;
    op_e              op_q;
    logic [PTR_W:0]   depth_q;
    logic [WIDTH-1:0] top_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             busy_q;
    logic             result_valid_q;
    logic             err_overflow_q;
    logic             err_underflow_q;
    logic             err_drop_q;

    logic [WIDTH-1:0] alu_r;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_a_idx;
    logic [PTR_W-1:0] rd_b_idx;
    logic             full;
    logic             clr_req;
    logic             push_req;

    // Stack addressing and request decode; CLR in IDLE swallows a same-cycle push.
    always_comb begin
        wr_idx   = depth_q[PTR_W-1:0];
        rd_b_idx = wr_idx - IDX1_C;
        rd_a_idx = wr_idx - IDX2_C;
        full     = (depth_q == DEPTH_C);
        clr_req  = op_valid && (op == OP_CLR);
        push_req = (state_q == S_IDLE) && num_valid && !clr_req;
    end

    rpn_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .r  (alu_r)
    );

    // Stack storage: operand pushes in IDLE, result write-back in WRITE.
    always_ff @(posedge clk) begin
        if (push_req && !full) begin
            mem[wr_idx] <= num_in;
        end else if (state_q == S_WRITE) begin
            mem[rd_a_idx] <= r_q;
        end
    end

    // Operator sequencer with stack pointer, top-of-stack and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            op_q            <= OP_ADD;
            depth_q         <= '0;
            top_q           <= '0;
            a_q             <= '0;
            b_q             <= '0;
            r_q             <= '0;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_drop_q      <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clr_req) begin
                        depth_q         <= '0;
                        top_q           <= '0;
                        err_overflow_q  <= 1'b0;
                        err_underflow_q <= 1'b0;
                        err_drop_q      <= 1'b0;
                    end else begin
                        // A same-cycle push lands first so FETCH sees the post-push depth.
                        if (num_valid) begin
                            if (!full) begin
                                depth_q <= depth_q + ONE_C;
                                top_q   <= num_in;
                            end else begin
                                err_overflow_q <= 1'b1;
                            end
                        end
                        if (op_valid) begin
                            op_q    <= op_e'(op);
                            state_q <= S_FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (depth_q < TWO_C) begin
                        err_underflow_q <= 1'b1;
                        state_q         <= S_IDLE;
                        busy_q          <= 1'b0;
                    end else begin
                        a_q     <= mem[rd_a_idx];
                        b_q     <= mem[rd_b_idx];
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_q     <= alu_r;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    top_q          <= r_q;
                    depth_q        <= depth_q - ONE_C;
                    result_valid_q <= 1'b1;
                    state_q        <= S_IDLE;
                    busy_q         <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if ((state_q != S_IDLE) && (num_valid || op_valid)) begin
                err_drop_q <= 1'b1;
            end
        end
    end

    assign top           = top_q;
    assign depth         = depth_q;
    assign busy          = busy_q;
    assign result_valid  = result_valid_q;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
    assign err_drop      = err_drop_q;

endmodule

// File: tb/tb_rpn_stack_eval.sv
// Bench for rpn_stack_eval: directed scenarios plus a randomized
// token stream, checked against a queue-based stack model.
module tb_rpn_stack_eval;

    localparam int W = 16;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          num_valid = 1'b0;
    logic [W-1:0]  num_in = '0;
    logic          op_valid = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  top;
    logic [3:0]    depth;
    logic          busy;
    logic          result_valid;
    logic          err_overflow;
    logic          err_underflow;
    logic          err_drop;

    int unsigned stk[$];
    bit m_ov;
    bit m_un;
    bit m_dr;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rpn_stack_eval #(
        .WIDTH (W),
        .DEPTH (D),
        .PTR_W (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .num_valid     (num_valid),
        .num_in        (num_in),
        .op_valid      (op_valid),
        .op            (op),
        .top           (top),
        .depth         (depth),
        .busy          (busy),
        .result_valid  (result_valid),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_drop      (err_drop)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned m_top();
        return (stk.size() != 0) ? stk[$] : 0;
    endfunction

    function automatic void m_push(input int unsigned v);
        if (stk.size() < D) stk.push_back(v);
        else m_ov = 1'b1;
    endfunction

    function automatic void m_clear();
        stk.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        m_dr = 1'b0;
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, ".top"},   32'(top),           m_top());
        check_eq({tag, ".depth"}, 32'(depth),         32'(stk.size()));
        check_eq({tag, ".busy"},  32'(busy),          0);
        check_eq({tag, ".ovf"},   32'(err_overflow),  32'(m_ov));
        check_eq({tag, ".unf"},   32'(err_underflow), 32'(m_un));
        check_eq({tag, ".drop"},  32'(err_drop),      32'(m_dr));
    endtask

    task automatic do_push(input logic [W-1:0] v, input string tag);
        num_valid = 1'b1;
        num_in    = v;
        tick();
        num_valid = 1'b0;
        m_push(v);
        check_eq({tag, ".rv"}, 32'(result_valid), 0);
        check_state(tag);
    endtask

    // Issue an operator; optionally push in the same cycle and/or poke an input while busy.
    task automatic do_op(input logic [1:0] opc, input bit with_push, input logic [W-1:0] v,
                         input bit drop, input string tag);
        int unsigned a;
        int unsigned b;
        int unsigned r;
        bit under;
        op_valid  = 1'b1;
        op        = opc;
        num_valid = with_push;
        num_in    = v;
        tick();
        op_valid  = 1'b0;
        num_valid = 1'b0;
        if (opc == 2'b11) begin
            m_clear();
            check_state({tag, ".clr"});
            return;
        end
        if (with_push) m_push(v);
        under = (stk.size() < 2);
        check_eq({tag, ".busy1"}, 32'(busy), 1);
        check_eq({tag, ".rv0"}, 32'(result_valid), 0);
        if (drop) begin
            if ($urandom_range(0, 1) == 1) begin
                op_valid = 1'b1;
                op       = 2'b11;
            end else begin
                num_valid = 1'b1;
                num_in    = 16'hBEEF;
            end
        end
        tick();
        op_valid  = 1'b0;
        num_valid = 1'b0;
        if (drop) m_dr = 1'b1;
        if (under) begin
            m_un = 1'b1;
            check_eq({tag, ".rv_u1"}, 32'(result_valid), 0);
            check_state({tag, ".unf"});
            tick();
            check_eq({tag, ".rv_u2"}, 32'(result_valid), 0);
            tick();
            check_eq({tag, ".rv_u3"}, 32'(result_valid), 0);
            check_state({tag, ".unf_end"});
            return;
        end
        check_eq({tag, ".busy2"}, 32'(busy), 1);
        check_eq({tag, ".rv1"}, 32'(result_valid), 0);
        tick();
        check_eq({tag, ".busy3"}, 32'(busy), 1);
        check_eq({tag, ".rv2"}, 32'(result_valid), 0);
        tick();
        b = stk.pop_back();
        a = stk.pop_back();
        case (opc)
            2'b00:   r = (a + b) % 65536;
            2'b01:   r = (a + 65536 - b) % 65536;
            default: r = (a * b) % 65536;
        endcase
        stk.push_back(r);
        check_eq({tag, ".rv3"}, 32'(result_valid), 1);
        check_state({tag, ".res"});
        tick();
        check_eq({tag, ".rv_once"}, 32'(result_valid), 0);
    endtask

    initial begin
        logic [1:0] opc;
        logic [W-1:0] v;
        m_clear();
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("reset.rv", 32'(result_valid), 0);
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 123 + 4
        do_push(16'd123, "add.p1");
        do_push(16'd4, "add.p2");
        do_op(2'b00, 1'b0, '0, 1'b0, "add");
        check_eq("add.top127", 32'(top), 127);

        // 10 - 3, then 3 - 10 wraps
        do_push(16'd10, "sub.p1");
        do_push(16'd3, "sub.p2");
        do_op(2'b01, 1'b0, '0, 1'b0, "sub");
        check_eq("sub.top7", 32'(top), 7);
        do_op(2'b11, 1'b0, '0, 1'b0, "sub.clr");
        do_push(16'd3, "subw.p1");
        do_push(16'd10, "subw.p2");
        do_op(2'b01, 1'b0, '0, 1'b0, "subw");
        check_eq("subw.topFFF9", 32'(top), 32'hFFF9);
        check_eq("subw.depth1", 32'(depth), 1);

        // 300 * 300 truncated
        do_op(2'b11, 1'b0, '0, 1'b0, "mul.clr");
        do_push(16'd300, "mul.p1");
        do_push(16'd300, "mul.p2");
        do_op(2'b10, 1'b0, '0, 1'b0, "mul");
        check_eq("mul.top24464", 32'(top), 24464);

        // underflow then CLR
        do_op(2'b11, 1'b0, '0, 1'b0, "unf.clr");
        do_push(16'd5, "unf.p1");
        do_op(2'b00, 1'b0, '0, 1'b0, "unf");
        check_eq("unf.flag", 32'(err_underflow), 1);
        check_eq("unf.top5", 32'(top), 5);
        do_op(2'b11, 1'b0, '0, 1'b0, "unf.clr2");

        // overflow, then drop during busy
        for (int i = 1; i <= 9; i++) do_push(16'(i), "ovf.p");
        check_eq("ovf.flag", 32'(err_overflow), 1);
        check_eq("ovf.top8", 32'(top), 8);
        do_op(2'b00, 1'b0, '0, 1'b1, "drop");
        check_eq("drop.top15", 32'(top), 15);
        check_eq("drop.depth7", 32'(depth), 7);
        check_eq("drop.flag", 32'(err_drop), 1);

        // push + op on same edge, then same with reset during EXEC
        do_op(2'b11, 1'b0, '0, 1'b0, "same.clr");
        do_push(16'd2, "same.p1");
        do_op(2'b00, 1'b1, 16'd6, 1'b0, "same");
        check_eq("same.top8", 32'(top), 8);
        do_op(2'b11, 1'b0, '0, 1'b0, "rst.clr");
        do_push(16'd2, "rst.p1");
        op_valid  = 1'b1;
        op        = 2'b00;
        num_valid = 1'b1;
        num_in    = 16'd6;
        tick();
        op_valid  = 1'b0;
        num_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        m_clear();
        check_eq("rst.rv", 32'(result_valid), 0);
        check_state("rst.mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rst.rv_after", 32'(result_valid), 0);
        end
        check_state("rst.end");

        // randomized token stream
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400));
            if ($urandom_range(0, 9) < 6) begin
                do_push(v, "rnd.push");
            end else begin
                opc = 2'($urandom_range(0, 3));
                if (opc == 2'b11 && $urandom_range(0, 3) != 0) opc = 2'($urandom_range(0, 2));
                do_op(opc, ($urandom_range(0, 3) == 0), v, ($urandom_range(0, 4) == 0), "rnd.op");
            end
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
